// File: rtl/debounce_counter_n.sv
// debounce_counter_n: four debounced buttons driving an up/down counter with a latched LED display; DEBOUNCE_AUTOREPEAT_EN adds hold-to-repeat on inc/dec.
module debounce_counter_n #(
  parameter int WIDTH = 8,
  parameter int DEB_CYCLES = 250000,
  parameter int BTN_ACTIVE_LOW = 1,
  parameter int WRAP = 1,
  parameter int LED_INVERT = 1
`ifdef DEBOUNCE_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_PERIOD = 2500000
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       btn,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] led,
  output logic [3:0]       press
);
  localparam int RW = $clog2(DEB_CYCLES + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(DEB_CYCLES);
  localparam logic [WIDTH-1:0] INV = (LED_INVERT != 0) ? '1 : '0;
  localparam logic [3:0] POL = (BTN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  logic [3:0] s1, s2, stable;
  logic [RW-1:0] run [4];
  logic step_inc, step_dec;
  logic [WIDTH-1:0] up, dn;
  // the run counter must sit at RUN_MAX for one more edge before acceptance
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      press <= '0;
      for (int i = 0; i < 4; i++) run[i] <= '0;
    end else begin
      s1 <= btn ^ POL;
      s2 <= s1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= 1'b0;
        if (s2[i] == stable[i]) run[i] <= '0;
        else if (run[i] == RUN_MAX) begin
          stable[i] <= s2[i];
          run[i] <= '0;
          press[i] <= s2[i];
        end else run[i] <= run[i] + 1'b1;
      end
    end
  end
`ifdef DEBOUNCE_AUTOREPEAT_EN
  logic arm, alone, rep;
  logic [31:0] t;
  assign alone = stable[0] ^ stable[3];
  assign rep = arm && alone && t == '0;
  always_ff @(posedge clock) begin
    if (reset || press[1] || !alone) begin
      arm <= 1'b0;
      t <= '0;
    end else if (press[0] || press[3]) begin
      arm <= 1'b1;
      t <= 32'(REPEAT_DELAY - 1);
    end else if (arm) t <= (t == '0) ? 32'(REPEAT_PERIOD - 1) : t - 1'b1;
  end
  assign step_inc = press[0] | (rep & stable[0]);
  assign step_dec = press[3] | (rep & stable[3]);
`else
  assign step_inc = press[0];
  assign step_dec = press[3];
`endif
  always_comb begin
    up = (WRAP != 0 || count != '1) ? count + 1'b1 : count;
    dn = (WRAP != 0 || count != '0) ? count - 1'b1 : count;
  end
  // show samples the count before this cycle's clr/inc/dec takes effect
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      led <= INV;
    end else begin
      if (press[2]) led <= count ^ INV;
      count <= press[1] ? '0 : (step_inc && !step_dec) ? up : (step_dec && !step_inc) ? dn : count;
    end
  end
endmodule
